// File: rtl/crc_append_p.sv
// AXI-Stream CRC trailer appender: places a sideband CRC at the first empty
// byte lane of each last beat, spilling into one extra beat when it does not fit.
module crc_append_p #(
  parameter int DATA_W = 512,
  parameter int CRC_W  = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clock,
  input  logic                  srst,
  input  logic                  i_tvalid,
  output logic                  i_tready,
  input  logic [DATA_W-1:0]     i_tdata,
  input  logic [DATA_W/8-1:0]   i_tkeep,
  input  logic                  i_tlast,
  input  logic [CRC_W-1:0]      i_crc,
  input  logic                  i_crc_en,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic [DATA_W-1:0]     o_tdata,
  output logic [DATA_W/8-1:0]   o_tkeep,
  output logic                  o_tlast,
  output logic                  o_keep_err,
  output logic [CNT_W-1:0]      o_pkt_cnt,
  output logic [CNT_W-1:0]      o_ext_cnt
);

  localparam int NB = DATA_W / 8;
  localparam int CB = CRC_W / 8;

  typedef enum logic {PASS, EXTRA} state_t;

  state_t            state;
  logic              run;
  logic [CRC_W-1:0]  res_data_p1;
  logic [CB-1:0]     res_keep_p1;

  int                n;
  logic              ovf;
  logic              holey;
  logic              free;
  logic              in_hs;
  logic [DATA_W-1:0] app_data;
  logic [NB-1:0]     app_keep;
  logic [CRC_W-1:0]  res_data;
  logic [CB-1:0]     res_keep;

  function automatic int first_zero(input logic [NB-1:0] keep);
    int idx;
    idx = NB;
    for (int k = NB - 1; k >= 0; k--)
      if (!keep[k]) idx = k;
    return idx;
  endfunction

  function automatic logic has_hole(input logic [NB-1:0] keep);
    logic seen_zero;
    logic bad;
    seen_zero = 1'b0;
    bad       = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (!keep[k]) seen_zero = 1'b1;
      else if (seen_zero) bad = 1'b1;
    end
    return bad;
  endfunction

  assign free     = !o_tvalid || o_tready;
  assign i_tready = run && (state == PASS) && free;
  assign in_hs    = i_tvalid && i_tready;

  // Stage 0: byte-lane placement of the CRC on the incoming last beat
  always_comb begin
    n        = first_zero(i_tkeep);
    ovf      = (n + CB > NB);
    holey    = has_hole(i_tkeep);
    app_data = '0;
    app_keep = '0;
    res_data = '0;
    res_keep = '0;
    for (int k = 0; k < NB; k++) begin
      if (k < n)
        app_data[8*k +: 8] = i_tdata[8*k +: 8];
      else if (k < n + CB)
        app_data[8*k +: 8] = i_crc[8*(k-n) +: 8];
      app_keep[k] = (k < n + CB);
    end
    // CRC bytes that did not fit are shifted down to lane 0 of the extra beat
    for (int j = 0; j < CB; j++) begin
      if (NB - n + j < CB) begin
        res_data[8*j +: 8] = i_crc[8*(NB-n+j) +: 8];
        res_keep[j]        = 1'b1;
      end
    end
  end

  // Stage 1: output register, residue holding and status counters
  always_ff @(posedge clock or negedge srst) begin
    if (!srst) begin
      state       <= PASS;
      run         <= 1'b0;
      res_data_p1 <= '0;
      res_keep_p1 <= '0;
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_tkeep     <= '0;
      o_tlast     <= 1'b0;
      o_keep_err  <= 1'b0;
      o_pkt_cnt   <= '0;
      o_ext_cnt   <= '0;
    end else begin
      run        <= 1'b1;
      o_keep_err <= 1'b0;
      if (o_tvalid && o_tready && o_tlast)
        o_pkt_cnt <= o_pkt_cnt + 1'b1;
      case (state)
        PASS: begin
          if (free) begin
            if (in_hs) begin
              o_tvalid   <= 1'b1;
              o_keep_err <= i_tlast && holey;
              if (i_tlast && i_crc_en) begin
                o_tdata <= app_data;
                o_tkeep <= app_keep;
                o_tlast <= !ovf;
                if (ovf) begin
                  state       <= EXTRA;
                  res_data_p1 <= res_data;
                  res_keep_p1 <= res_keep;
                end
              end else begin
                o_tdata <= i_tdata;
                o_tkeep <= i_tkeep;
                o_tlast <= i_tlast;
              end
            end else begin
              o_tvalid <= 1'b0;
            end
          end
        end
        EXTRA: begin
          if (free) begin
            o_tvalid  <= 1'b1;
            o_tdata   <= DATA_W'(res_data_p1);
            o_tkeep   <= NB'(res_keep_p1);
            o_tlast   <= 1'b1;
            o_ext_cnt <= o_ext_cnt + 1'b1;
            state     <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_append_p.sv
// Bench for crc_append_p: directed table, reset-in-EXTRA sequence and random
// back-to-back traffic compared against a byte-stream reference model.
module tb_crc_append_p;

  localparam int DW = 512;
  localparam int CW = 32;
  localparam int CNTW = 32;
  localparam int NB = DW / 8;
  localparam int CB = CW / 8;

  logic            clock = 1'b0;
  logic            srst = 1'b0;
  logic            i_tvalid = 1'b0;
  logic            i_tready;
  logic [DW-1:0]   i_tdata = '0;
  logic [NB-1:0]   i_tkeep = '0;
  logic            i_tlast = 1'b0;
  logic [CW-1:0]   i_crc = '0;
  logic            i_crc_en = 1'b0;
  logic            o_tvalid;
  logic            o_tready;
  logic [DW-1:0]   o_tdata;
  logic [NB-1:0]   o_tkeep;
  logic            o_tlast;
  logic            o_keep_err;
  logic [CNTW-1:0] o_pkt_cnt;
  logic [CNTW-1:0] o_ext_cnt;

  crc_append_p #(.DATA_W(DW), .CRC_W(CW), .CNT_W(CNTW)) dut (
    .clock(clock), .srst(srst),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast), .i_crc(i_crc), .i_crc_en(i_crc_en),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .o_tkeep(o_tkeep), .o_tlast(o_tlast), .o_keep_err(o_keep_err),
    .o_pkt_cnt(o_pkt_cnt), .o_ext_cnt(o_ext_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int            nbeats;
    logic [NB-1:0] last_keep;
    logic [CW-1:0] crc;
    logic          en;
    int            exp_nout;
    logic [NB-1:0] exp_last_keep;
    int            exp_stall;
    int            exp_kerr;
  } case_t;

  beat_t in_q[$];
  beat_t exp_q[$];
  case_t tbl[7];

  int n_pass = 0;
  int n_total = 0;
  int out_beats = 0;
  int stall_cnt = 0;
  int kerr_cnt = 0;
  int pkt_exp = 0;
  int ext_exp = 0;
  int kerr_exp = 0;
  int rdy_mode = 0;
  bit meas = 1'b0;
  logic [NB-1:0] last_out_keep = '0;

  task automatic check_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_s(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: with append enabled, the packet is its payload bytes (up to the
  // first keep hole of the last beat) followed by the CRC bytes, re-chunked.
  task automatic model_pkt(input logic [CW-1:0] crc, input logic en);
    logic [7:0] bq[$];
    beat_t      b;
    int         n;
    int         nout;
    bit         seen_zero;
    bit         hole;
    beat_t      lastb;
    lastb = in_q[in_q.size()-1];
    seen_zero = 0;
    hole = 0;
    for (int k = 0; k < NB; k++) begin
      if (!lastb.keep[k]) seen_zero = 1;
      else if (seen_zero) hole = 1;
    end
    if (hole) kerr_exp++;
    pkt_exp++;
    if (!en) begin
      foreach (in_q[i]) exp_q.push_back(in_q[i]);
      return;
    end
    foreach (in_q[i]) begin
      if (!in_q[i].last) begin
        for (int k = 0; k < NB; k++) bq.push_back(in_q[i].data[8*k +: 8]);
      end else begin
        n = NB;
        for (int k = 0; k < NB; k++) begin
          if (!in_q[i].keep[k]) begin
            n = k;
            break;
          end
        end
        for (int k = 0; k < n; k++) bq.push_back(in_q[i].data[8*k +: 8]);
      end
    end
    for (int j = 0; j < CB; j++) bq.push_back(crc[8*j +: 8]);
    nout = 0;
    while (bq.size() > 0) begin
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < NB && bq.size() > 0; k++) begin
        b.data[8*k +: 8] = bq.pop_front();
        b.keep[k] = 1'b1;
      end
      b.last = (bq.size() == 0);
      exp_q.push_back(b);
      nout++;
    end
    if (nout > in_q.size()) ext_exp++;
  endtask

  task automatic send_pkt(input int nb, input logic [NB-1:0] lk, input logic [CW-1:0] crc, input logic en);
    beat_t b;
    bit    hs;
    in_q.delete();
    for (int i = 0; i < nb; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[32*w +: 32] = $urandom;
      b.keep = (i == nb - 1) ? lk : '1;
      b.last = (i == nb - 1);
      in_q.push_back(b);
    end
    model_pkt(crc, en);
    foreach (in_q[i]) begin
      i_tvalid = 1'b1;
      i_tdata  = in_q[i].data;
      i_tkeep  = in_q[i].keep;
      i_tlast  = in_q[i].last;
      i_crc    = in_q[i].last ? crc : CW'($urandom);
      i_crc_en = in_q[i].last ? en : 1'($urandom_range(0, 1));
      hs = 0;
      for (int c = 0; c < 1000 && !hs; c++) begin
        @(negedge clock);
        hs = i_tready;
        @(posedge clock);
        #1;
      end
      if (!hs) check_s("handshake_timeout", 64'(hs), 64'd1);
    end
    i_tvalid = 1'b0;
    i_crc    = CW'($urandom);
    i_crc_en = ~en;
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && (exp_q.size() > 0 || o_tvalid); c++) @(posedge clock);
    if (exp_q.size() > 0) check_s("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Output monitor: every valid cycle must present the model's next beat
  always @(negedge clock) begin
    if (srst && o_tvalid) begin
      if (exp_q.size() == 0) begin
        check_s("unexpected_beat", 64'(o_tvalid), 64'd0);
      end else begin
        check_v("beat_data", o_tdata, exp_q[0].data);
        check_s("beat_keep", 64'(o_tkeep), 64'(exp_q[0].keep));
        check_s("beat_last", 64'(o_tlast), 64'(exp_q[0].last));
        if (o_tready) begin
          out_beats++;
          last_out_keep = o_tkeep;
          void'(exp_q.pop_front());
        end
      end
    end
    if (srst && meas && !i_tready) stall_cnt++;
    if (srst && o_keep_err) kerr_cnt++;
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0: o_tready = 1'b1;
        1: o_tready = ~o_tready;
        default: o_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic [NB-1:0] lk;
    int            r;
    int            len;

    tbl[0] = '{2, 64'hF, 32'hDDCCBBAA, 1'b1, 2, 64'hFF, 0, 0};
    tbl[1] = '{2, 64'h3FFF_FFFF_FFFF_FFFF, 32'hDDCCBBAA, 1'b1, 3, 64'h3, 1, 0};
    tbl[2] = '{2, 64'h0FFF_FFFF_FFFF_FFFF, 32'h44332211, 1'b1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
    tbl[3] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 32'h87654321, 1'b1, 3, 64'hF, 1, 0};
    tbl[4] = '{1, 64'h0B, 32'hCAFEF00D, 1'b1, 1, 64'h3F, 0, 1};
    tbl[5] = '{2, 64'h0, 32'h0BADBEEF, 1'b1, 2, 64'hF, 0, 0};
    tbl[6] = '{2, 64'h7, 32'h13579BDF, 1'b0, 2, 64'h7, 0, 0};

    repeat (3) @(posedge clock);
    #1;
    check_s("rst_tvalid", 64'(o_tvalid), 64'd0);
    check_v("rst_tdata", o_tdata, '0);
    check_s("rst_tkeep", 64'(o_tkeep), 64'd0);
    check_s("rst_tlast", 64'(o_tlast), 64'd0);
    check_s("rst_keep_err", 64'(o_keep_err), 64'd0);
    check_s("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    check_s("rst_ext_cnt", 64'(o_ext_cnt), 64'd0);
    check_s("rst_tready", 64'(i_tready), 64'd0);
    @(negedge clock);
    srst = 1'b1;
    @(posedge clock);
    #1;
    check_s("tready_after_release", 64'(i_tready), 64'd1);

    rdy_mode = 0;
    foreach (tbl[t]) begin
      out_beats = 0;
      stall_cnt = 0;
      kerr_cnt  = 0;
      meas      = 1'b1;
      send_pkt(tbl[t].nbeats, tbl[t].last_keep, tbl[t].crc, tbl[t].en);
      drain();
      meas = 1'b0;
      check_s($sformatf("case%0d_nout", t), 64'(out_beats), 64'(tbl[t].exp_nout));
      check_s($sformatf("case%0d_last_keep", t), 64'(last_out_keep), 64'(tbl[t].exp_last_keep));
      check_s($sformatf("case%0d_stall", t), 64'(stall_cnt), 64'(tbl[t].exp_stall));
      check_s($sformatf("case%0d_keep_err", t), 64'(kerr_cnt), 64'(tbl[t].exp_kerr));
      check_s($sformatf("case%0d_pkt_cnt", t), 64'(o_pkt_cnt), 64'(pkt_exp));
      check_s($sformatf("case%0d_ext_cnt", t), 64'(o_ext_cnt), 64'(ext_exp));
    end

    // Reset while the extra beat is pending: it must never appear
    send_pkt(2, '1, 32'h11223344, 1'b1);
    @(negedge clock);
    #1;
    srst = 1'b0;
    #1;
    exp_q.delete();
    pkt_exp  = 0;
    ext_exp  = 0;
    kerr_exp = 0;
    check_s("extra_rst_tvalid", 64'(o_tvalid), 64'd0);
    check_v("extra_rst_tdata", o_tdata, '0);
    check_s("extra_rst_tkeep", 64'(o_tkeep), 64'd0);
    check_s("extra_rst_tlast", 64'(o_tlast), 64'd0);
    check_s("extra_rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    check_s("extra_rst_ext_cnt", 64'(o_ext_cnt), 64'd0);
    @(posedge clock);
    #1;
    check_s("extra_rst_tready", 64'(i_tready), 64'd0);
    @(negedge clock);
    srst = 1'b1;
    @(posedge clock);
    #1;
    check_s("extra_release_tready", 64'(i_tready), 64'd1);
    out_beats = 0;
    repeat (5) @(posedge clock);
    #1;
    check_s("extra_never_emitted", 64'(out_beats), 64'd0);
    check_s("extra_post_ext_cnt", 64'(o_ext_cnt), 64'd0);
    send_pkt(2, 64'hF, 32'hA5A5_5A5A, 1'b1);
    drain();
    check_s("post_rst_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

    // Back-to-back random traffic under toggling, then random, back-pressure
    kerr_cnt = 0;
    kerr_exp = 0;
    for (int p = 0; p < 40; p++) begin
      rdy_mode = (p < 15) ? 1 : 2;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        lk = {$urandom, $urandom};
      end else begin
        len = (r < 5) ? $urandom_range(NB - CB, NB) : $urandom_range(0, NB);
        lk = '0;
        for (int k = 0; k < len; k++) lk[k] = 1'b1;
      end
      send_pkt($urandom_range(1, 3), lk, CW'($urandom), ($urandom_range(0, 4) != 0));
    end
    rdy_mode = 0;
    drain();
    check_s("rand_pkt_cnt", 64'(o_pkt_cnt), 64'(pkt_exp));
    check_s("rand_ext_cnt", 64'(o_ext_cnt), 64'(ext_exp));
    check_s("rand_keep_err", 64'(kerr_cnt), 64'(kerr_exp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
